// File: rtl/packer_96bit_if.sv
// packer_96bit_if -- byte-stream handshake bundle used on both sides of the packer.
//   data  [31:0] bytes, left-aligned; first byte in [31:24]
//   bytes [2:0]  valid byte count (input side) / byte mask count (output side)
//   valid        producer has data this cycle
//   ready        consumer accepts data this cycle
// modport master drives data/bytes/valid; modport slave drives ready.
interface packer_96bit_if;
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        valid;
    logic        ready;

    modport master (output data, output bytes, output valid, input ready);
    modport slave  (input data, input bytes, input valid, output ready);
endinterface

// File: rtl/packer_96bit.sv
// packer_96bit -- packs 0-4 byte input chunks into full 32-bit output words,
// holding up to 12 bytes in a 96-bit MSB-first accumulator. A flush pulse
// drains everything held, including a final partial word, then pulses done.
//
// Ports:
//   clk          clock, rising edge
//   rstN         asynchronous active-low reset
//   in_s         input stream  (data/bytes/valid in, ready out)
//   out_m        output stream (data/bytes=mask/valid out, ready in)
//   flush        one-cycle drain request
//   done         one-cycle pulse once a flush has fully drained
//   fill         bytes currently held, 0-12
//   out_byte_cnt running total of bytes emitted
//
// Build option: define PACKER_BYTE_COUNT_EN to enable the out_byte_cnt
// counter; without it out_byte_cnt is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal packing; emits only full 4-byte words
// ST_FLUSH | no input accepted; emits remaining bytes, last word partial
// ST_DONE  | one-cycle done pulse, returns to ST_RUN
module packer_96bit (
    input  logic                  clk,
    input  logic                  rstN,
    packer_96bit_if.slave         in_s,
    packer_96bit_if.master        out_m,
    input  logic                  flush,
    output logic                  done,
    output logic [3:0]            fill,
    output logic [31:0]           out_byte_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [95:0] acc;
    logic [95:0] acc_next;
    logic [3:0]  fill_next;

    logic        in_ready;
    logic        out_valid;
    logic [2:0]  out_mask;

    logic        in_fire;
    logic        out_fire;
    logic [2:0]  in_bytes_eff;
    logic [2:0]  shift_bytes;
    logic [2:0]  add_bytes;
    logic [3:0]  base;
    logic [31:0] in_masked;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // No input can arrive in FLUSH, so fill only reaches zero by draining.
                if ((fill == 4'd0) || (out_fire && (fill_next == 4'd0))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ---------------- output decode (registers only) ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_mask  = 3'd0;
        done      = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready  = (fill <= 4'd8);
                out_valid = (fill >= 4'd4);
                out_mask  = 3'd4;
            end
            ST_FLUSH: begin
                out_valid = (fill != 4'd0);
                out_mask  = (fill >= 4'd4) ? 3'd4 : fill[2:0];
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign in_s.ready  = in_ready;
    assign out_m.valid = out_valid;
    assign out_m.bytes = out_mask;
    assign out_m.data  = acc[95:64];

    // ---------------- datapath ----------------
    always_comb begin
        in_bytes_eff = (in_s.bytes <= 3'd4) ? in_s.bytes : 3'd0;
        in_fire      = in_s.valid & in_ready;
        out_fire     = out_valid & out_m.ready;
        shift_bytes  = out_fire ? out_mask : 3'd0;
        add_bytes    = in_fire ? in_bytes_eff : 3'd0;
        base         = fill - {1'b0, shift_bytes};
        // Keep only the top add_bytes bytes so unused accumulator bytes stay zero.
        in_masked    = in_s.data & ~(32'hFFFF_FFFF >> {add_bytes, 3'b000});
        acc_next     = (acc << {shift_bytes, 3'b000})
                     | ({in_masked, 64'd0} >> {base, 3'b000});
        fill_next    = base + {1'b0, add_bytes};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc  <= 96'd0;
            fill <= 4'd0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
        end
    end

`ifdef PACKER_BYTE_COUNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_byte_cnt <= 32'd0;
        end else if (out_fire) begin
            out_byte_cnt <= out_byte_cnt + {29'd0, out_mask};
        end
    end
`else
    assign out_byte_cnt = 32'd0;
`endif

endmodule

// File: doc/packer_96bit.md
PACKER_96BIT -- requirements
Module: packer_96bit

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rstN  input  1  reset, asynchronous assert, active-low.
REQ-003 in_data  input  32  input bytes, left-aligned; first byte in [31:24].
REQ-004 in_bytes  input  3  count of valid bytes in in_data, 0-4; values 5-7 are treated as 0.
REQ-005 in_valid  input  1  in_data/in_bytes valid; transfer (in_fire) = in_valid & in_ready.
REQ-006 in_ready  output  1  packer accepts input this cycle.
REQ-007 flush  input  1  one-cycle pulse: drain all held bytes, including a partial last word.
REQ-008 out_data  output  32  always acc[95:64]; first byte in [31:24].
REQ-009 out_mask  output  3  valid bytes in out_data: 4 in RUN, 1-4 in FLUSH.
REQ-010 out_valid  output  1  out_data valid; transfer (out_fire) = out_valid & out_ready.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 done  output  1  one-cycle pulse after a flush has fully drained.
REQ-013 fill  output  4  registered count of bytes held, 0-12.
REQ-014 out_byte_cnt  output  32  total bytes emitted, present per REQ-030.

Function
REQ-015 Storage: 96-bit register acc, MSB-first; valid bytes occupy the top fill bytes; unused bytes SHALL be zero.
REQ-016 States: RUN, FLUSH, DONE.
REQ-017 in_ready = (state==RUN) & (fill<=8), decoded from registers only.
REQ-018 RUN: out_valid = (fill>=4); out_mask = 4.
REQ-019 Per cycle, with s = out_fire ? out_mask : 0 and a = in_fire ? in_bytes : 0:
  - acc shifts left by s bytes;
  - the top a bytes of in_data are glued at byte offset fill-s;
  - fill_next = fill - s + a.
REQ-020 Input and output transfers in the same cycle SHALL both take effect; no bubble.
REQ-021 Latency: a byte accepted in cycle N is visible on out_data/fill from cycle N+1.
REQ-022 in_fire with in_bytes=0 SHALL leave acc and fill unchanged.
REQ-023 Byte order is preserved; no byte is lost or duplicated.
REQ-024 flush sampled in RUN SHALL move the block to FLUSH; a same-cycle in_fire is included in the drain.
  - flush in FLUSH or DONE is ignored.
REQ-025 FLUSH: out_valid = (fill>0); out_mask = min(fill,4).
  - Move to DONE when fill==0, or when out_fire takes fill to 0.
REQ-026 DONE: done=1 for exactly one cycle, fill=0, out_valid=0; next state is RUN.
REQ-027 out_valid high with out_ready low SHALL hold out_data and out_mask stable.

Reset
REQ-028 rstN low SHALL asynchronously clear acc, fill, out_byte_cnt, done and out_valid, and set state=RUN.
  - in_ready is 1 after reset.
  - Reset mid-flush discards all held data; done is not pulsed.
REQ-029 Reset release is synchronous to clk; first transfer possible on the first edge after release.

Configuration
REQ-030 Macro PACKER_BYTE_COUNT_EN.
  - Defined: out_byte_cnt adds out_mask on each out_fire, wrapping modulo 2^32; cleared only by reset.
  - Undefined: out_byte_cnt is tied to 0 and no counter logic exists.

Verification
REQ-031 Four in_fires of 3 bytes: 0xAABBCC, 0xDDEEFF, 0x112233, 0x445566, with out_ready=1 -> words 0xAABBCCDD, 0xEEFF1122, 0x33445566; fill ends at 0.
REQ-032 Back-pressure:
  - fill=8 plus in_fire of 4 bytes with out_ready=0 -> fill=12 and in_ready=0;
  - then out_ready=1 for one cycle -> fill=8 and in_ready=1.
REQ-033 Partial flush: 6 bytes 01..06 then flush -> 0x01020304 mask 4, then 0x05060000 mask 2, then done pulse, state RUN.
REQ-034 flush with fill=0 -> no out_valid; done one cycle later.
REQ-035 rstN low during FLUSH with fill=5 -> fill=0, out_valid=0, no done; then 4 bytes 0xCAFEBABE -> out_data 0xCAFEBABE.
REQ-036 With PACKER_BYTE_COUNT_EN, 10 bytes emitted then flush of 2 -> out_byte_cnt=12; without the macro -> out_byte_cnt=0.
